ram_io_responder: RTL
=====================

Name: ram_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus (address, data out, data in, write strobe) and its io_buffer_full input.
- Provides a 2^ADDR_WIDTH-byte single-port RAM for the 0x00000–0x1FFFF region and the memory-mapped I/O window at mem_a[17:16]==2'b11.
- The I/O window holds a UART tx FIFO, a UART rx FIFO, a free-running cycle counter and a sticky halt flag.
- Sits between the cpu top and the board/testbench UART.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address width (128 KB).
- TX_DEPTH_LOG2, 4, log2 of tx FIFO entries (16).
- RX_DEPTH_LOG2, 4, log2 of rx FIFO entries (16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_address_in  in  32  byte address from CPU; only [17:0] decoded
- cpu_data_in  in  8  write data from CPU
- cpu_rw_signal_in  in  1  1 = write, 0 = read; a request is issued every cycle
- cpu_data_out  out  8  read data, valid the cycle after the address
- io_buffer_full_out  out  1  tx FIFO near full, to CPU io_buffer_full
- rx_valid_in  in  1  host pushes a byte into the rx FIFO
- rx_data_in  in  8  host rx byte
- rx_full_out  out  1  rx FIFO full; host must not push
- tx_valid_out  out  1  tx FIFO non-empty
- tx_data_out  out  8  head of tx FIFO
- tx_ready_in  in  1  host consumes tx head when tx_valid_out && tx_ready_in
- halt_out  out  1  sticky: program wrote 0x30004
- tx_overflow_out  out  1  sticky: CPU wrote the tx port while the tx FIFO was full

Behaviour:
- Reset values:
  - cpu_data_out = 0, halt_out = 0, tx_overflow_out = 0.
  - Both FIFOs empty, so tx_valid_out = 0, rx_full_out = 0, io_buffer_full_out = 0.
  - Cycle counter = 0 and counter snapshot = 0.
  - RAM contents are not reset.
- Decode: io_sel = (cpu_address_in[17:16] == 2'b11). Otherwise RAM at index cpu_address_in[ADDR_WIDTH-1:0].
- RAM read: cpu_data_out <= ram[addr] at the next clk edge. Latency is exactly 1 cycle.
- RAM write: ram[addr] <= cpu_data_in at the edge. cpu_data_out holds its previous value.
- IO read 0x30000:
  - If the rx FIFO is non-empty: pop it and cpu_data_out <= head.
  - If empty: cpu_data_out <= 0x00 and nothing is popped.
- IO read 0x30004–0x30007:
  - cpu_data_out <= byte (addr[1:0]) of the snapshot, little-endian.
  - A read of 0x30004 first loads snapshot <= cycle counter and returns counter[7:0] in the same response. This makes the 4-byte LW sequence coherent.
- Other IO read addresses return 0x00.
- IO write 0x30000:
  - If cpu_data_in != 0, push to the tx FIFO.
  - If cpu_data_in == 0, ignore.
  - If the FIFO is full, drop the byte and set tx_overflow_out.
- IO write 0x30004:
  - Set halt_out.
  - Push 0x00 into the tx FIFO; the full rule is the same as for 0x30000.
  - Any further tx pushes are still accepted.
- Other IO write addresses are ignored.
- io_buffer_full_out = (tx count >= TX_DEPTH-2), registered. The slack covers the 1-cycle flag latency plus one in-flight write.
- tx FIFO:
  - Pop on tx_valid_out && tx_ready_in.
  - Simultaneous push and pop when full: the push wins the freed slot (no overflow).
  - Simultaneous push and pop when empty: the pushed byte appears on tx_data_out the next cycle.
  - Pointers wrap modulo depth; count width is depth-log2 + 1.
- rx FIFO:
  - A push while rx_full_out is high is dropped.
  - A simultaneous CPU pop and host push are both serviced.
  - A CPU pop and host push to an empty FIFO in the same cycle return 0x00; the byte remains queued.
- Cycle counter: +1 every cycle after reset deasserts, 32-bit wrap. It keeps counting after halt.
- Reset mid-operation: FIFOs, counter, snapshot and flags clear at the edge. RAM keeps its contents. An in-flight read response is lost and cpu_data_out = 0.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> cpu_data_out = 0xA5 exactly one cycle after the read address; 0x0001FFFF round-trips 0x3C.
- Write bytes 'H' 0x48, 0x00, 'i' 0x69 to 0x30000 with tx_ready_in = 1 -> tx stream is 0x48, 0x69; the zero is skipped.
- Hold tx_ready_in = 0 and write 15 nonzero bytes -> io_buffer_full_out = 1 after the 14th write is counted. The 16th and 17th writes: 16 fits, 17 sets tx_overflow_out. Then release tx_ready_in -> 16 bytes drain in order.
- Host pushes 0x31 and 0x32, CPU reads 0x30000 three times -> responses 0x31, 0x32, 0x00.
- After reset, wait 99 cycles and read 0x30004..0x30007 on consecutive cycles -> bytes reassemble to the counter value at the 0x30004 cycle (0x00000063 ±0 per the bench's cycle alignment); counter wrap from 0xFFFFFFFF goes to 0.
- Write 0x30004 -> halt_out = 1 next cycle and a 0x00 appears on tx; assert rst mid-stream -> halt_out, FIFOs and counter clear while RAM data written earlier reads back intact.

Source files
------------

// File: rtl/ram_io_responder_if.sv
// CPU byte-wide memory bus between the core and ram_io_responder.
interface ram_io_responder_if;
    logic [31:0] cpu_address_in;
    logic [7:0]  cpu_data_in;
    logic        cpu_rw_signal_in;
    logic [7:0]  cpu_data_out;
    logic        io_buffer_full_out;

    modport master (
        output cpu_address_in, cpu_data_in, cpu_rw_signal_in,
        input  cpu_data_out, io_buffer_full_out
    );

    modport slave (
        input  cpu_address_in, cpu_data_in, cpu_rw_signal_in,
        output cpu_data_out, io_buffer_full_out
    );
endinterface

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped UART tx/rx FIFOs, cycle counter and halt flag at 0x3xxxx.
module ram_io_responder #(
    parameter int unsigned ADDR_WIDTH    = 17,
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned RX_DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_io_responder_if.slave bus,
    input  logic              rx_valid_in,
    input  logic [7:0]        rx_data_in,
    output logic              rx_full_out,
    output logic              tx_valid_out,
    output logic [7:0]        tx_data_out,
    input  logic              tx_ready_in,
    output logic              halt_out,
    output logic              tx_overflow_out
);
    localparam int unsigned RamDepth = 2 ** ADDR_WIDTH;
    localparam int unsigned TxDepth  = 2 ** TX_DEPTH_LOG2;
    localparam int unsigned RxDepth  = 2 ** RX_DEPTH_LOG2;
    localparam logic [17:0] IoData   = 18'h30000;
    localparam logic [17:0] IoTimer  = 18'h30004;

    typedef logic [TX_DEPTH_LOG2-1:0] tx_ptr_t;
    typedef logic [TX_DEPTH_LOG2:0]   tx_cnt_t;
    typedef logic [RX_DEPTH_LOG2-1:0] rx_ptr_t;
    typedef logic [RX_DEPTH_LOG2:0]   rx_cnt_t;

    // Address decode
    logic [17:0]           addr;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  io_sel, wr_en, rd_en;
    logic                  io_data_rd, io_data_wr, io_timer_rd, io_timer_wr, io_snap_rd;
    logic                  unused_addr;

    assign addr        = bus.cpu_address_in[17:0];
    assign ram_idx     = bus.cpu_address_in[ADDR_WIDTH-1:0];
    assign unused_addr = ^bus.cpu_address_in[31:18];
    assign io_sel      = (addr[17:16] == 2'b11);
    assign wr_en       = bus.cpu_rw_signal_in;
    assign rd_en       = !bus.cpu_rw_signal_in;
    assign io_data_rd  = rd_en && (addr == IoData);
    assign io_data_wr  = wr_en && (addr == IoData);
    assign io_timer_rd = rd_en && (addr == IoTimer);
    assign io_timer_wr = wr_en && (addr == IoTimer);
    assign io_snap_rd  = rd_en && (addr[17:2] == IoTimer[17:2]);

    // tx FIFO
    logic [7:0] tx_mem [TxDepth];
    tx_ptr_t    tx_wr_q, tx_rd_q;
    tx_cnt_t    tx_cnt_q, tx_cnt_d;
    logic       tx_full, tx_push_req, tx_push, tx_pop;
    logic [7:0] tx_push_data;
    logic       io_full_q, tx_ovf_q;

    always_comb begin
        tx_full      = (tx_cnt_q == tx_cnt_t'(TxDepth));
        tx_pop       = (tx_cnt_q != '0) && tx_ready_in;
        tx_push_req  = (io_data_wr && (bus.cpu_data_in != 8'h00)) || io_timer_wr;
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        tx_push      = tx_push_req && (!tx_full || tx_pop);
        tx_push_data = io_timer_wr ? 8'h00 : bus.cpu_data_in;
        tx_cnt_d     = tx_cnt_q + tx_cnt_t'(tx_push) - tx_cnt_t'(tx_pop);
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q] <= tx_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            io_full_q <= 1'b0;
            tx_ovf_q  <= 1'b0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + tx_ptr_t'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + tx_ptr_t'(1);
            tx_cnt_q  <= tx_cnt_d;
            io_full_q <= (tx_cnt_d >= tx_cnt_t'(TxDepth - 2));
            if (tx_push_req && !tx_push) tx_ovf_q <= 1'b1;
        end
    end

    assign tx_valid_out           = (tx_cnt_q != '0);
    assign tx_data_out            = tx_mem[tx_rd_q];
    assign tx_overflow_out        = tx_ovf_q;
    assign bus.io_buffer_full_out = io_full_q;

    // rx FIFO
    logic [7:0] rx_mem [RxDepth];
    rx_ptr_t    rx_wr_q, rx_rd_q;
    rx_cnt_t    rx_cnt_q, rx_cnt_d;
    logic       rx_full, rx_push, rx_pop;

    always_comb begin
        rx_full  = (rx_cnt_q == rx_cnt_t'(RxDepth));
        rx_push  = rx_valid_in && !rx_full;
        rx_pop   = io_data_rd && (rx_cnt_q != '0);
        rx_cnt_d = rx_cnt_q + rx_cnt_t'(rx_push) - rx_cnt_t'(rx_pop);
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_q] <= rx_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + rx_ptr_t'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + rx_ptr_t'(1);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign rx_full_out = rx_full;

    // Read mux, counter, snapshot, halt
    logic [7:0]  ram [RamDepth];
    logic [7:0]  data_out_q, io_rdata;
    logic [31:0] cycle_q, snap_q;
    logic        halt_q;

    always_comb begin
        io_rdata = 8'h00;
        if (io_data_rd) begin
            io_rdata = rx_pop ? rx_mem[rx_rd_q] : 8'h00;
        end else if (io_timer_rd) begin
            // Snapshot loads this cycle; byte 0 comes straight from the live counter.
            io_rdata = cycle_q[7:0];
        end else if (io_snap_rd) begin
            case (addr[1:0])
                2'd0:    io_rdata = snap_q[7:0];
                2'd1:    io_rdata = snap_q[15:8];
                2'd2:    io_rdata = snap_q[23:16];
                default: io_rdata = snap_q[31:24];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !io_sel) begin
            ram[ram_idx] <= bus.cpu_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= 8'h00;
            cycle_q    <= '0;
            snap_q     <= '0;
            halt_q     <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (io_timer_rd) snap_q <= cycle_q;
            if (io_timer_wr) halt_q <= 1'b1;
            if (rd_en) data_out_q <= io_sel ? io_rdata : ram[ram_idx];
        end
    end

    assign bus.cpu_data_out = data_out_q;
    assign halt_out         = halt_q;
endmodule
